// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage
//   Memory-access pipeline stage. It latches one instruction from EXE and
//   extracts and extends load data from the synchronous data SRAM. It hands
//   the result to WB and publishes a hazard/forwarding bundle back to ID.
//
//   The SRAM returns read data exactly one cycle after EXE issues the request.
//   That is the first cycle the instruction sits in MEM. If WB stalls MEM, the
//   first-cycle data is held in a local buffer. Later SRAM traffic cannot then
//   corrupt the load result.
//
// Ports
//   clk, resetn          clock, synchronous active-low reset
//   es2ms_valid          EXE offers an instruction
//   ms_allowin           MEM can accept this cycle
//   es_pc                instruction PC
//   es_ld_op             one-hot {ld_b, ld_bu, ld_h, ld_hu, ld_w}
//   es_res_from_mem      writeback value comes from memory
//   es_rf_we             register write enable
//   es_rf_waddr          destination register
//   es_alu_result        ALU result, or byte address for loads
//   es_ex_zip            upstream exception bits
//   es_ale               EXE address-misalign flag
//   data_sram_rdata      SRAM read data (valid the cycle after the request)
//   ws_allowin           WB can accept
//   wb_ex                flush from WB
//   ms2ws_valid          MEM offers an instruction to WB
//   ms_pc                PC of the instruction in MEM
//   ms_rf_we             gated register write enable
//   ms_rf_waddr          destination register
//   ms_rf_wdata          writeback data
//   ms_ex_zip            {es_ex_zip, es_ale} as captured
//   ms_ex                MEM holds an excepting instruction
//   ms_rf_zip            {res_from_mem, rf_we, rf_waddr, rf_wdata} for ID
// -----------------------------------------------------------------------------
module mem_stage #(
  parameter int EX_W = 84
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            es2ms_valid,
  output logic            ms_allowin,
  input  logic [31:0]     es_pc,
  input  logic [4:0]      es_ld_op,
  input  logic            es_res_from_mem,
  input  logic            es_rf_we,
  input  logic [4:0]      es_rf_waddr,
  input  logic [31:0]     es_alu_result,
  input  logic [EX_W-1:0] es_ex_zip,
  input  logic            es_ale,
  input  logic [31:0]     data_sram_rdata,
  input  logic            ws_allowin,
  input  logic            wb_ex,
  output logic            ms2ws_valid,
  output logic [31:0]     ms_pc,
  output logic            ms_rf_we,
  output logic [4:0]      ms_rf_waddr,
  output logic [31:0]     ms_rf_wdata,
  output logic [EX_W:0]   ms_ex_zip,
  output logic            ms_ex,
  output logic [38:0]     ms_rf_zip
);

  // Bit positions inside the one-hot load opcode.
  localparam int LD_B  = 4;
  localparam int LD_BU = 3;
  localparam int LD_H  = 2;
  localparam int LD_HU = 1;
  localparam int LD_W  = 0;

  // Pick the addressed byte from a word.
  function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] a);
    logic [7:0] b;
    case (a)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    return b;
  endfunction

  // Pick the addressed half-word from a word.
  function automatic logic [15:0] half_sel(input logic [31:0] w, input logic a1);
    return a1 ? w[31:16] : w[15:0];
  endfunction

  // Extract the addressed field and sign- or zero-extend it to 32 bits.
  function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] a,
                                           input logic [4:0] op);
    logic signed [7:0]  sb;
    logic signed [15:0] sh;
    logic [31:0]        r;
    sb = signed'(byte_sel(w, a));
    sh = signed'(half_sel(w, a[1]));
    r  = 32'd0;
    if (op[LD_B])       r = 32'(sb);
    else if (op[LD_BU]) r = {24'd0, byte_sel(w, a)};
    else if (op[LD_H])  r = 32'(sh);
    else if (op[LD_HU]) r = {16'd0, half_sel(w, a[1])};
    else if (op[LD_W])  r = w;
    return r;
  endfunction

  logic            ms_valid_q, ms_valid_d;
  logic            cap_q;
  logic [31:0]     hold_q;
  logic [31:0]     pc_q;
  logic [4:0]      ld_op_q;
  logic            res_from_mem_q;
  logic            rf_we_q;
  logic [4:0]      rf_waddr_q;
  logic [31:0]     alu_result_q;
  logic [EX_W:0]   ex_zip_q;

  logic            capture;
  logic [31:0]     ld_word;
  logic [31:0]     ld_data;
  logic            we_gated;

  // ready_go is constantly 1, so MEM drains whenever WB accepts.
  assign ms_allowin = ~ms_valid_q | ws_allowin;
  assign capture    = es2ms_valid & ms_allowin;

  // A WB flush wins over an incoming instruction.
  always_comb begin
    ms_valid_d = ms_valid_q;
    if (wb_ex)           ms_valid_d = 1'b0;
    else if (ms_allowin) ms_valid_d = es2ms_valid;
  end

  // ---- EXE -> MEM boundary ----
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ms_valid_q     <= 1'b0;
      cap_q          <= 1'b0;
      hold_q         <= 32'd0;
      pc_q           <= 32'd0;
      ld_op_q        <= 5'd0;
      res_from_mem_q <= 1'b0;
      rf_we_q        <= 1'b0;
      rf_waddr_q     <= 5'd0;
      alu_result_q   <= 32'd0;
      ex_zip_q       <= '0;
    end else begin
      ms_valid_q <= ms_valid_d;
      // cap_q marks the single cycle where the SRAM output belongs to us.
      cap_q      <= capture;
      if (cap_q) hold_q <= data_sram_rdata;
      if (capture) begin
        pc_q           <= es_pc;
        ld_op_q        <= es_ld_op;
        res_from_mem_q <= es_res_from_mem;
        rf_we_q        <= es_rf_we;
        rf_waddr_q     <= es_rf_waddr;
        alu_result_q   <= es_alu_result;
        ex_zip_q       <= {es_ex_zip, es_ale};
      end
    end
  end

  // ---- MEM -> WB boundary ----
  // On the first cycle, take live SRAM data. On later stall cycles, take the buffered copy.
  assign ld_word     = cap_q ? data_sram_rdata : hold_q;
  assign ld_data     = load_ext(ld_word, alu_result_q[1:0], ld_op_q);

  assign ms2ws_valid = ms_valid_q;
  assign ms_pc       = pc_q;
  assign ms_ex_zip   = ex_zip_q;
  assign ms_ex       = ms_valid_q & (|ex_zip_q);
  assign we_gated    = ms_valid_q & rf_we_q & ~ms_ex;
  assign ms_rf_we    = we_gated;
  assign ms_rf_waddr = rf_waddr_q;
  assign ms_rf_wdata = res_from_mem_q ? ld_data : alu_result_q;
  assign ms_rf_zip   = {res_from_mem_q & ms_valid_q, we_gated, rf_waddr_q, ms_rf_wdata};

endmodule

// File: tb/tb_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_stage
//   Directed bench for mem_stage. Inputs change 1 ns after a rising edge.
//   Outputs are checked 3 ns after that edge, well clear of the next edge.
// -----------------------------------------------------------------------------
module tb_mem_stage;
  localparam int EX_W = 84;

  localparam logic [4:0] OP_B  = 5'b10000;
  localparam logic [4:0] OP_BU = 5'b01000;
  localparam logic [4:0] OP_H  = 5'b00100;
  localparam logic [4:0] OP_HU = 5'b00010;
  localparam logic [4:0] OP_W  = 5'b00001;

  logic            clk = 1'b0;
  logic            resetn;
  logic            es2ms_valid;
  logic            ms_allowin;
  logic [31:0]     es_pc;
  logic [4:0]      es_ld_op;
  logic            es_res_from_mem;
  logic            es_rf_we;
  logic [4:0]      es_rf_waddr;
  logic [31:0]     es_alu_result;
  logic [EX_W-1:0] es_ex_zip;
  logic            es_ale;
  logic [31:0]     data_sram_rdata;
  logic            ws_allowin;
  logic            wb_ex;
  logic            ms2ws_valid;
  logic [31:0]     ms_pc;
  logic            ms_rf_we;
  logic [4:0]      ms_rf_waddr;
  logic [31:0]     ms_rf_wdata;
  logic [EX_W:0]   ms_ex_zip;
  logic            ms_ex;
  logic [38:0]     ms_rf_zip;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_stage #(.EX_W(EX_W)) dut (
    .clk(clk), .resetn(resetn), .es2ms_valid(es2ms_valid), .ms_allowin(ms_allowin),
    .es_pc(es_pc), .es_ld_op(es_ld_op), .es_res_from_mem(es_res_from_mem),
    .es_rf_we(es_rf_we), .es_rf_waddr(es_rf_waddr), .es_alu_result(es_alu_result),
    .es_ex_zip(es_ex_zip), .es_ale(es_ale), .data_sram_rdata(data_sram_rdata),
    .ws_allowin(ws_allowin), .wb_ex(wb_ex), .ms2ws_valid(ms2ws_valid), .ms_pc(ms_pc),
    .ms_rf_we(ms_rf_we), .ms_rf_waddr(ms_rf_waddr), .ms_rf_wdata(ms_rf_wdata),
    .ms_ex_zip(ms_ex_zip), .ms_ex(ms_ex), .ms_rf_zip(ms_rf_zip)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] pc, input logic [4:0] op, input logic res,
                       input logic we, input logic [4:0] wa, input logic [31:0] alu,
                       input logic ale);
    es2ms_valid     = 1'b1;
    es_pc           = pc;
    es_ld_op        = op;
    es_res_from_mem = res;
    es_rf_we        = we;
    es_rf_waddr     = wa;
    es_alu_result   = alu;
    es_ale          = ale;
  endtask

  // A load enters MEM. The SRAM answers in the next cycle and the result is checked.
  task automatic load_chk(input string tag, input logic [4:0] op, input logic [31:0] addr,
                          input logic [31:0] rdata, input logic [31:0] exp);
    issue(32'h0000_1000, op, 1'b1, 1'b1, 5'd7, addr, 1'b0);
    tick();
    es2ms_valid     = 1'b0;
    data_sram_rdata = rdata;
    #2;
    chk({tag, "_wdata"}, 64'(ms_rf_wdata), 64'(exp));
  endtask

  initial begin
    resetn          = 1'b0;
    es2ms_valid     = 1'b1;
    es_pc           = 32'hAAAA_0000;
    es_ld_op        = 5'd0;
    es_res_from_mem = 1'b0;
    es_rf_we        = 1'b1;
    es_rf_waddr     = 5'd3;
    es_alu_result   = 32'h0000_1234;
    es_ex_zip       = '0;
    es_ale          = 1'b1;
    data_sram_rdata = 32'hFFFF_FFFF;
    ws_allowin      = 1'b1;
    wb_ex           = 1'b0;

    // Reset holds everything at zero even with EXE offering an instruction.
    repeat (3) tick();
    #2;
    chk("rst_allowin", 64'(ms_allowin), 64'd1);
    chk("rst_valid",   64'(ms2ws_valid), 64'd0);
    chk("rst_pc",      64'(ms_pc), 64'd0);
    chk("rst_we",      64'(ms_rf_we), 64'd0);
    chk("rst_waddr",   64'(ms_rf_waddr), 64'd0);
    chk("rst_wdata",   64'(ms_rf_wdata), 64'd0);
    chk("rst_exzip",   64'(|ms_ex_zip), 64'd0);
    chk("rst_ex",      64'(ms_ex), 64'd0);
    chk("rst_rfzip",   64'(ms_rf_zip), 64'd0);

    es2ms_valid = 1'b0;
    es_ale      = 1'b0;
    resetn      = 1'b1;
    tick();

    // Load extraction and extension.
    load_chk("ldb_1003", OP_B, 32'h0000_1003, 32'h8012_3456, 32'hFFFF_FF80);
    chk("ldb_we",    64'(ms_rf_we), 64'd1);
    chk("ldb_valid", 64'(ms2ws_valid), 64'd1);
    chk("ldb_zip",   64'(ms_rf_zip), {25'd0, 1'b1, 1'b1, 5'd7, 32'hFFFF_FF80});
    load_chk("ldbu_1001", OP_BU, 32'h0000_1001, 32'h8012_3456, 32'h0000_0034);
    load_chk("ldbu_1002", OP_BU, 32'h0000_1002, 32'h8012_3456, 32'h0000_0012);
    load_chk("ldhu_2002", OP_HU, 32'h0000_2002, 32'hBEEF_1234, 32'h0000_BEEF);
    load_chk("ldh_2002",  OP_H,  32'h0000_2002, 32'hBEEF_1234, 32'hFFFF_BEEF);
    load_chk("ldh_2000",  OP_H,  32'h0000_2000, 32'h1234_8001, 32'hFFFF_8001);
    load_chk("ldw_3000",  OP_W,  32'h0000_3000, 32'hCAFE_F00D, 32'hCAFE_F00D);
    tick();
    #2;
    chk("drain_valid", 64'(ms2ws_valid), 64'd0);

    // Flush from WB kills a valid instruction.
    issue(32'h0000_0200, 5'd0, 1'b0, 1'b1, 5'd9, 32'h0000_00AB, 1'b0);
    tick();
    es2ms_valid = 1'b0;
    #2;
    chk("wbex_pre_valid", 64'(ms2ws_valid), 64'd1);
    wb_ex = 1'b1;
    tick();
    wb_ex = 1'b0;
    #2;
    chk("wbex_valid", 64'(ms2ws_valid), 64'd0);
    chk("wbex_zip",   64'(ms_rf_zip[38:37]), 64'd0);

    // Flush and a new capture in the same cycle: the flush wins.
    issue(32'h0000_0204, 5'd0, 1'b0, 1'b1, 5'd9, 32'h0000_00CD, 1'b0);
    wb_ex = 1'b1;
    tick();
    wb_ex       = 1'b0;
    es2ms_valid = 1'b0;
    #2;
    chk("wbex_cap_valid", 64'(ms2ws_valid), 64'd0);

    // Misaligned load raises an exception and suppresses the write.
    issue(32'h0000_0300, OP_W, 1'b1, 1'b1, 5'd4, 32'h0000_1001, 1'b1);
    tick();
    es2ms_valid     = 1'b0;
    es_ale          = 1'b0;
    data_sram_rdata = 32'h1234_5678;
    #2;
    chk("ale_ex",    64'(ms_ex), 64'd1);
    chk("ale_we",    64'(ms_rf_we), 64'd0);
    chk("ale_zip0",  64'(ms_ex_zip[0]), 64'd1);
    chk("ale_rfzip", 64'(ms_rf_zip[37]), 64'd0);
    tick();

    // A WB stall keeps the first-cycle SRAM data; EXE must not overwrite MEM.
    issue(32'h0000_0400, OP_W, 1'b1, 1'b1, 5'd5, 32'h0000_4000, 1'b0);
    ws_allowin = 1'b0;
    tick();
    issue(32'h0000_9999, 5'd0, 1'b0, 1'b1, 5'd6, 32'h0000_7777, 1'b0);
    data_sram_rdata = 32'h1111_1111;
    #2;
    chk("stall_first", 64'(ms_rf_wdata), 64'h1111_1111);
    for (int i = 0; i < 3; i++) begin
      tick();
      data_sram_rdata = 32'hDEAD_BEEF;
      #2;
      chk($sformatf("stall_wdata%0d", i), 64'(ms_rf_wdata), 64'h1111_1111);
      chk($sformatf("stall_pc%0d", i), 64'(ms_pc), 64'h0000_0400);
      chk($sformatf("stall_allowin%0d", i), 64'(ms_allowin), 64'd0);
    end
    es2ms_valid = 1'b0;
    ws_allowin  = 1'b1;
    #1;
    chk("release_allowin", 64'(ms_allowin), 64'd1);
    tick();
    #2;
    chk("release_valid", 64'(ms2ws_valid), 64'd0);

    // Four back-to-back ALU ops stream through without bubbles.
    issue(32'h0000_0500, 5'd0, 1'b0, 1'b1, 5'd10, 32'h0000_0A00, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i < 3)
        issue(32'h0000_0500 + 32'(4 * (i + 1)), 5'd0, 1'b0, 1'b1, 5'(10 + i + 1),
              32'h0000_0A00 + 32'(i + 1), 1'b0);
      else
        es2ms_valid = 1'b0;
      #2;
      chk($sformatf("b2b_valid%0d", i), 64'(ms2ws_valid), 64'd1);
      chk($sformatf("b2b_pc%0d", i), 64'(ms_pc), 64'(32'h0000_0500 + 32'(4 * i)));
      chk($sformatf("b2b_wdata%0d", i), 64'(ms_rf_wdata), 64'(32'h0000_0A00 + 32'(i)));
    end
    tick();
    #2;
    chk("b2b_end_valid", 64'(ms2ws_valid), 64'd0);

    // Reset during a stall discards the held instruction.
    issue(32'h0000_0600, OP_W, 1'b1, 1'b1, 5'd8, 32'h0000_5000, 1'b0);
    ws_allowin = 1'b0;
    tick();
    es2ms_valid     = 1'b0;
    data_sram_rdata = 32'h0000_0055;
    #2;
    chk("rststall_pre", 64'(ms2ws_valid), 64'd1);
    resetn = 1'b0;
    tick();
    resetn     = 1'b1;
    ws_allowin = 1'b1;
    #2;
    chk("rststall_valid", 64'(ms2ws_valid), 64'd0);
    chk("rststall_pc",    64'(ms_pc), 64'd0);
    chk("rststall_wdata", 64'(ms_rf_wdata), 64'd0);
    tick();
    #2;
    chk("rststall_after", 64'(ms2ws_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Hard bound so the run always terminates.
  initial begin
    #20000;
    $display("FAIL timeout: observed no end expected end");
    $fatal(1, "timeout");
  end

endmodule
